// File: rtl/time_set_ctrl_pkg.sv
// Shared types, field addresses and wrap helpers for the time-setting controller.
// The counter blocks decode the same ADDR_* constants.
package time_set_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_SEC  = 2'b00;
  localparam logic [1:0] ADDR_MIN  = 2'b01;
  localparam logic [1:0] ADDR_HOUR = 2'b10;

  localparam logic [5:0] MAX_SEC  = 6'd59;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_HOUR = 6'd23;

  // Out-of-range inputs snap back into range rather than propagating.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
    return ((v == 6'd0) || (v > max)) ? max : v - 6'd1;
  endfunction

  function automatic logic [5:0] field_max(input state_e s);
    case (s)
      SET_H:   return MAX_HOUR;
      SET_M:   return MAX_MIN;
      default: return MAX_SEC;
    endcase
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button inputs, counter read-back and the load/addrs/data_in write port.
// master = time-setting controller, slave = board buttons plus counter blocks.
interface time_set_ctrl_if;
  logic       tc_time_base;
  logic       btn_set;
  logic       btn_up;
  logic       btn_down;
  logic [5:0] q_seconds;
  logic [5:0] q_minutes;
  logic [4:0] q_hours;
  logic       load;
  logic [1:0] addrs;
  logic [5:0] data_in;
  logic [2:0] edit_field;

  modport master (
    input  tc_time_base, btn_set, btn_up, btn_down, q_seconds, q_minutes, q_hours,
    output load, addrs, data_in, edit_field
  );

  modport slave (
    output tc_time_base, btn_set, btn_up, btn_down, q_seconds, q_minutes, q_hours,
    input  load, addrs, data_in, edit_field
  );
endinterface

// File: rtl/time_set_ctrl_btn_debounce.sv
// Raw button -> 2-flop sync -> stability counter -> one-cycle pulse per accepted press.
// Pulse appears a few cycles plus DEBOUNCE_CYCLES after the raw edge; holding never repeats.
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        level_q, level_d;
  logic        pulse_q, pulse_d;
  logic [19:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    // cnt_q counts earlier samples that disagreed with the accepted level.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= DEBOUNCE_CYCLES - 20'd1) begin
      level_d = sync2_q;
      cnt_d   = '0;
      pulse_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven hours/minutes/seconds editor issuing single-cycle load writes.
// Write lands one cycle after the debounced pulse; timeout returns to IDLE without writing.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
  parameter logic [5:0]  TIMEOUT_TICKS   = 6'd30
) (
  input logic           clk,
  input logic           reset,
  time_set_ctrl_if.master bus
);

  logic set_p, up_p, down_p, any_p;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
    .clk(clk), .rst_n(reset), .btn_raw(bus.btn_set), .pulse(set_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst_n(reset), .btn_raw(bus.btn_up), .pulse(up_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst_n(reset), .btn_raw(bus.btn_down), .pulse(down_p)
  );

  state_e     state_q, state_d;
  logic [5:0] edit_q, edit_d;
  logic [1:0] addrs_q, addrs_d;
  logic       load_q, load_d;
  logic [2:0] field_q, field_d;
  logic [5:0] tmo_q, tmo_d;

  assign any_p = set_p | up_p | down_p;

  always_comb begin
    state_d = state_q;
    edit_d  = edit_q;
    addrs_d = addrs_q;
    load_d  = 1'b0;
    tmo_d   = tmo_q;

    if (state_q == IDLE || any_p) begin
      tmo_d = '0;
    end else if (bus.tc_time_base && tmo_q < TIMEOUT_TICKS) begin
      tmo_d = tmo_q + 6'd1;
    end

    case (state_q)
      IDLE: if (set_p) begin
        state_d = SET_H;
        edit_d  = {1'b0, bus.q_hours};
        addrs_d = ADDR_HOUR;
      end
      SET_H: if (set_p) begin
        state_d = SET_M;
        edit_d  = bus.q_minutes;
        addrs_d = ADDR_MIN;
      end
      SET_M: if (set_p) begin
        state_d = SET_S;
        edit_d  = bus.q_seconds;
        addrs_d = ADDR_SEC;
      end
      SET_S: if (set_p) begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // set_p beats an edit; up+down together cancel out.
    if (state_q != IDLE && !set_p) begin
      if (up_p ^ down_p) begin
        edit_d = up_p ? wrap_inc(edit_q, field_max(state_q))
                      : wrap_dec(edit_q, field_max(state_q));
        load_d = 1'b1;
      end else if (!any_p && tmo_q >= TIMEOUT_TICKS) begin
        state_d = IDLE;
      end
    end

    case (state_d)
      SET_H:   field_d = 3'b100;
      SET_M:   field_d = 3'b010;
      SET_S:   field_d = 3'b001;
      default: field_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      edit_q  <= '0;
      addrs_q <= ADDR_SEC;
      load_q  <= 1'b0;
      field_q <= 3'b000;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      edit_q  <= edit_d;
      addrs_q <= addrs_d;
      load_q  <= load_d;
      field_q <= field_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.load       = load_q;
  assign bus.addrs      = addrs_q;
  assign bus.data_in    = edit_q;
  assign bus.edit_field = field_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed, table-driven bench for time_set_ctrl with short debounce and timeout.
module tb_time_set_ctrl;

  localparam int A_SET = 0, A_UP = 1, A_DOWN = 2, A_BOTH = 3, A_SETUP = 4;

  typedef struct {
    int act;
    int qh, qm, qs;
    int loads;
    int field;
    int addrs;
    int data;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   load_cnt = 0;
  int   last_addrs = 0;
  int   last_data = 0;
  vec_t vt[18];

  time_set_ctrl_if bus();

  time_set_ctrl #(.DEBOUNCE_CYCLES(20'd4), .TIMEOUT_TICKS(6'd3)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.load) begin
      load_cnt   <= load_cnt + 1;
      last_addrs <= int'(bus.addrs);
      last_data  <= int'(bus.data_in);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic press(input logic s, input logic u, input logic d);
    @(negedge clk);
    bus.btn_set = s; bus.btn_up = u; bus.btn_down = d;
    repeat (12) @(negedge clk);
    bus.btn_set = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    bus.tc_time_base = 1'b1;
    @(negedge clk);
    bus.tc_time_base = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outputs(input string tag, input int field, input int addrs, input int data);
    check({tag, "_field"}, int'(bus.edit_field), field);
    check({tag, "_addrs"}, int'(bus.addrs), addrs);
    check({tag, "_data"},  int'(bus.data_in), data);
  endtask

  initial begin
    int n0;
    bus.tc_time_base = 1'b0;
    bus.btn_set = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    bus.q_hours = 5'd23; bus.q_minutes = 6'd10; bus.q_seconds = 6'd0;

    //          act      qh qm  qs  ld fld adr data
    vt[0]  = '{A_SET,    23, 10,  0, 0, 4, 2, 23};
    vt[1]  = '{A_UP,     23, 10,  0, 1, 4, 2,  0};
    vt[2]  = '{A_DOWN,   23, 10,  0, 1, 4, 2, 23};
    vt[3]  = '{A_BOTH,   23, 10,  0, 0, 4, 2, 23};
    vt[4]  = '{A_SETUP,  23, 10,  0, 0, 2, 1, 10};
    vt[5]  = '{A_UP,     23, 10,  0, 1, 2, 1, 11};
    vt[6]  = '{A_SET,    23, 10,  0, 0, 1, 0,  0};
    vt[7]  = '{A_DOWN,   23, 10,  0, 1, 1, 0, 59};
    vt[8]  = '{A_UP,     23, 10,  0, 1, 1, 0,  0};
    vt[9]  = '{A_UP,     23, 10,  0, 1, 1, 0,  1};
    vt[10] = '{A_SET,    23, 10,  0, 0, 0, 0,  1};
    vt[11] = '{A_UP,     23, 10,  0, 0, 0, 0,  1};
    vt[12] = '{A_SET,     5, 59, 30, 0, 4, 2,  5};
    vt[13] = '{A_SET,     5, 59, 30, 0, 2, 1, 59};
    vt[14] = '{A_UP,      5, 59, 30, 1, 2, 1,  0};
    vt[15] = '{A_DOWN,    5, 59, 30, 1, 2, 1, 59};
    vt[16] = '{A_SET,     5, 59, 30, 0, 1, 0, 30};
    vt[17] = '{A_SET,     5, 59, 30, 0, 0, 0, 30};

    repeat (3) @(negedge clk);
    check("rst_load", int'(bus.load), 0);
    check_outputs("rst", 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      bus.q_hours   = 5'(vt[i].qh);
      bus.q_minutes = 6'(vt[i].qm);
      bus.q_seconds = 6'(vt[i].qs);
      n0 = load_cnt;
      case (vt[i].act)
        A_SET:   press(1'b1, 1'b0, 1'b0);
        A_UP:    press(1'b0, 1'b1, 1'b0);
        A_DOWN:  press(1'b0, 1'b0, 1'b1);
        A_BOTH:  press(1'b0, 1'b1, 1'b1);
        default: press(1'b1, 1'b1, 1'b0);
      endcase
      check($sformatf("v%0d_loads", i), load_cnt - n0, vt[i].loads);
      if (vt[i].loads > 0) begin
        check($sformatf("v%0d_ld_addrs", i), last_addrs, vt[i].addrs);
        check($sformatf("v%0d_ld_data", i), last_data, vt[i].data);
      end
      check_outputs($sformatf("v%0d", i), vt[i].field, vt[i].addrs, vt[i].data);
    end

    // Bouncing up button: only the final stable level counts, once.
    bus.q_hours = 5'd7;
    press(1'b1, 1'b0, 1'b0);
    n0 = load_cnt;
    for (int k = 0; k < 20; k++) begin
      bus.btn_up = k[1];
      @(negedge clk);
    end
    bus.btn_up = 1'b1;
    repeat (12) @(negedge clk);
    bus.btn_up = 1'b0;
    repeat (12) @(negedge clk);
    check("bounce_loads", load_cnt - n0, 1);
    check("bounce_data", last_data, 8);
    check_outputs("bounce", 4, 2, 8);

    // Reset mid-SET_M with up held.
    press(1'b1, 1'b0, 1'b0);
    check("pre_rst_field", int'(bus.edit_field), 2);
    @(negedge clk);
    bus.btn_up = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_load", int'(bus.load), 0);
    check_outputs("mid_rst", 0, 0, 0);
    rst_n = 1'b1;
    n0 = load_cnt;
    repeat (15) @(negedge clk);
    bus.btn_up = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_loads", load_cnt - n0, 0);
    check("post_rst_field", int'(bus.edit_field), 0);
    bus.q_hours = 5'd23;
    press(1'b1, 1'b0, 1'b0);
    check_outputs("fresh_set", 4, 2, 23);

    // Timeout: three idle ticks abort to IDLE with no write.
    n0 = load_cnt;
    repeat (3) tick();
    check("tmo1_field", int'(bus.edit_field), 0);
    check("tmo1_loads", load_cnt - n0, 0);

    // A press after the second tick restarts the count.
    press(1'b1, 1'b0, 1'b0);
    n0 = load_cnt;
    repeat (2) tick();
    press(1'b0, 1'b1, 1'b0);
    repeat (2) tick();
    check("tmo2_hold_field", int'(bus.edit_field), 4);
    tick();
    check("tmo2_field", int'(bus.edit_field), 0);
    check("tmo2_loads", load_cnt - n0, 1);
    check("tmo2_data", last_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Pushbutton-driven time-setting controller that acts as the initiator of the clock's load/addrs/data_in write interface. It lets the user edit hours, minutes and seconds.
- Debounces three buttons, then walks a field-select FSM. Each edit is issued as a single-cycle load write to the seconds/minutes/hours counters.
- Reads back the current counter values, so each edit starts from the live time.
- Sits between board buttons and the counter blocks; edit_field drives the display's blink/indicator logic.

Parameters:
- DEBOUNCE_CYCLES, 20'd1000000: clk cycles a synchronized button level must stay stable before it is accepted (10 ms at 100 MHz).
- TIMEOUT_TICKS, 6'd30: tc_time_base ticks without any accepted press before editing aborts to IDLE.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  asynchronous, active-low reset.
- tc_time_base  in  1  one-cycle 1 Hz tick from the time base.
- btn_set  in  1  raw button: enter edit mode / advance field.
- btn_up  in  1  raw button: increment the selected field.
- btn_down  in  1  raw button: decrement the selected field.
- q_seconds  in  6  current seconds, 0..59.
- q_minutes  in  6  current minutes, 0..59.
- q_hours  in  5  current hours, 0..23.
- load  out  1  one-cycle write strobe to the counters.
- addrs  out  2  write target: 2'b00 seconds, 2'b01 minutes, 2'b10 hours; 2'b11 is never driven.
- data_in  out  6  write value, always equal to the edit register.
- edit_field  out  3  one-hot indicator {hours, minutes, seconds}; 3'b000 when not editing.

Behaviour:
- Reset (asynchronous, active-low) forces: load=0, addrs=2'b00, data_in=6'd0, edit_field=3'b000, state=IDLE, timeout counter=0, debouncers cleared. This applies at any time, including mid-edit; no partial write is issued.
- Button path:
  - 2-flop synchronizer, then a stability counter.
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive identical samples.
  - Each accepted 0->1 transition yields exactly one 1-cycle pulse: set_p, up_p or down_p.
  - Holding a button produces no repeat pulses.
- FSM states: IDLE, SET_H, SET_M, SET_S.
  - IDLE: set_p -> SET_H; the edit register captures {1'b0, q_hours} in the same cycle. up_p and down_p are ignored.
  - SET_H: set_p -> SET_M, capturing q_minutes.
  - SET_M: set_p -> SET_S, capturing q_seconds.
  - SET_S: set_p -> IDLE.
  - State changes never assert load.
- Edit arithmetic, in any SET_x state:
  - up_p: value+1; wraps 23->0 for hours and 59->0 for minutes/seconds.
  - down_p: value-1; wraps 0->23 for hours and 0->59 for minutes/seconds.
  - All arithmetic is 6-bit unsigned. A value out of range is never produced.
- Write timing:
  - A pulse in cycle N updates the edit register at the N+1 edge.
  - load=1 during cycle N+1 with data_in equal to the new value and addrs matching the current field.
  - load is registered and exactly one cycle wide per accepted up_p/down_p.
- Simultaneous events:
  - set_p with up_p/down_p in the same cycle: set_p wins and the edit is discarded.
  - up_p and down_p in the same cycle: both are ignored and no load is issued.
- Timeout:
  - Counts tc_time_base ticks while not in IDLE.
  - Cleared by any accepted pulse.
  - When the count reaches TIMEOUT_TICKS, the FSM returns to IDLE at the next cycle with no write.
  - Writes already issued remain in effect.
- addrs reflects the current field: hours in SET_H, minutes in SET_M, seconds in SET_S. In IDLE it holds its last value. data_in holds the edit register.
- edit_field = 3'b100 in SET_H, 3'b010 in SET_M, 3'b001 in SET_S, 3'b000 in IDLE.

Decomposition:
- Shared package holds:
  - State encoding localparams: IDLE, SET_H, SET_M, SET_S.
  - Address constants: ADDR_SEC=2'b00, ADDR_MIN=2'b01, ADDR_HOUR=2'b10. The counter blocks decode the same constants.
  - Limits: MAX_SEC=59, MAX_MIN=59, MAX_HOUR=23.
- One sub-module, btn_debounce: synchronizer, stability counter and rising-edge pulse, parameterized by DEBOUNCE_CYCLES. Instantiated three times.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_TICKS=3 for simulation):
- Reset asserted mid-SET_M with btn_up held -> all outputs 0 and state IDLE. After release, no load occurs until a fresh set press.
- q_hours=23: press set, then up -> edit_field=3'b100 and one load with addrs=2'b10, data_in=0. Press down -> load with data_in=23.
- Advance to SET_S with q_seconds=0: press down -> load with addrs=2'b00, data_in=59. Then press up twice -> two separate loads with data_in=0, then 1.
- btn_up bouncing 0/1 every 2 cycles for 20 cycles, then stable high -> exactly one load.
- Set and up accepted in the same cycle in SET_H -> state SET_M, no load. Up and down in the same cycle -> no load, field unchanged.
- Enter SET_H and apply 3 tc_time_base ticks with no press -> edit_field=3'b000 and no load. Repeat with a press after the 2nd tick -> timeout restarts, requiring 3 more ticks.
